// File: rtl/pwm_pkg.sv
// pwm_pkg: shared mode type, default widths and sizing helper for the PWM block
package pwm_pkg;
   typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_t;
   localparam int DEF_NUM_CH  = 16;
   localparam int DEF_CNT_W   = 8;
   localparam int DEF_PRESC_W = 8;
   // channel index width, kept at least one bit so a single-channel build still has a port
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared prescaler and up / up-down period counter with boundary detection
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CNT_W-1:0]   period,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               center_mode,
   output logic [CNT_W-1:0]   cnt,
   output logic               boundary
);
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   act_period_q, act_period_d;
   logic               dir_down_q, dir_down_d;
   pwm_mode_t          act_mode_q, act_mode_d;
   logic               tick;

   // next-state: a down-count reaching 1 (or a period of 1 at its peak) closes a centre period
   always_comb begin
      tick = presc_q == prescale;
      presc_d = tick ? '0 : presc_q + 1'b1;
      boundary = tick && (act_period_q == '0
         || (act_mode_q == PWM_EDGE && cnt_q == act_period_q)
         || (act_mode_q == PWM_CENTER && !dir_down_q && cnt_q == act_period_q && act_period_q == CNT_W'(1))
         || (act_mode_q == PWM_CENTER && dir_down_q && cnt_q <= CNT_W'(1)));
      act_period_d = boundary ? period : act_period_q;
      act_mode_d = boundary ? pwm_mode_t'(center_mode) : act_mode_q;
      cnt_d = cnt_q;
      dir_down_d = dir_down_q;
      if (boundary) begin
         cnt_d = '0;
         dir_down_d = 1'b0;
      end else if (tick) begin
         if (dir_down_q) cnt_d = cnt_q - 1'b1;
         else if (act_mode_q == PWM_CENTER && cnt_q == act_period_q) begin
            cnt_d = cnt_q - 1'b1;
            dir_down_d = 1'b1;
         end else cnt_d = cnt_q + 1'b1;
      end
   end

   // timebase state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q <= '0;
         cnt_q <= '0;
         dir_down_q <= 1'b0;
         act_period_q <= '0;
         act_mode_q <= PWM_EDGE;
      end else begin
         presc_q <= presc_d;
         cnt_q <= cnt_d;
         dir_down_q <= dir_down_d;
         act_period_q <= act_period_d;
         act_mode_q <= act_mode_d;
      end
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/pwm_multichannel.sv
// pwm_multichannel: NUM_CH PWM outputs on one timebase with double-buffered duty values
module pwm_multichannel
   import pwm_pkg::*;
#(
   parameter int  NUM_CH  = DEF_NUM_CH,
   parameter int  CNT_W   = DEF_CNT_W,
   parameter int  PRESC_W = DEF_PRESC_W,
   localparam int CH_W    = ch_w(NUM_CH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [CNT_W-1:0]   cfg_duty,
   input  logic [CNT_W-1:0]   period,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               center_mode,
   input  logic [NUM_CH-1:0]  en_out,
   input  logic [NUM_CH-1:0]  en_pwm,
   output logic [NUM_CH-1:0]  out,
   output logic               period_tick
);
   logic [CNT_W-1:0] cnt;
   logic             boundary;
   logic             period_tick_q, period_tick_d;

   pwm_timebase #(.CNT_W(CNT_W), .PRESC_W(PRESC_W)) u_timebase (
      .clk         (clk),
      .rst         (rst),
      .period      (period),
      .prescale    (prescale),
      .center_mode (center_mode),
      .cnt         (cnt),
      .boundary    (boundary)
   );

   // boundary pulse delayed one cycle to line up with the registered outputs
   always_comb begin
      period_tick_d = boundary;
   end

   // boundary pulse register
   always_ff @(posedge clk) begin
      if (rst) period_tick_q <= 1'b0;
      else period_tick_q <= period_tick_d;
   end

   assign period_tick = period_tick_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [CNT_W-1:0] pend_q, pend_d, act_q, act_d;
      logic             out_q, out_d, wr;
      // duty shadowing: a write on a boundary cycle bypasses pending straight into active
      always_comb begin
         wr = cfg_we && cfg_ch == CH_W'(i);
         pend_d = wr ? cfg_duty : pend_q;
         act_d = boundary ? (wr ? cfg_duty : pend_q) : act_q;
         out_d = en_out[i] && (!en_pwm[i] || cnt < act_q);
      end
      // per-channel duty and output registers
      always_ff @(posedge clk) begin
         if (rst) begin
            pend_q <= '0;
            act_q <= '0;
            out_q <= 1'b0;
         end else begin
            pend_q <= pend_d;
            act_q <= act_d;
            out_q <= out_d;
         end
      end
      assign out[i] = out_q;
   end
endmodule

// File: tb/tb_pwm_multichannel.sv
// tb_pwm_multichannel: directed checks of reset, prescaler, modes, duty shadowing and channel gating
module tb_pwm_multichannel;
   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [3:0]  cfg_ch;
   logic [7:0]  cfg_duty;
   logic [7:0]  period;
   logic [7:0]  prescale;
   logic        center_mode;
   logic [15:0] en_out;
   logic [15:0] en_pwm;
   logic [15:0] out;
   logic        period_tick;
   int          checks = 0;
   int          errors = 0;
   logic [63:0] o, t;
   int          n0, n1, n2, n3, bad;

   pwm_multichannel #(.NUM_CH(16), .CNT_W(8), .PRESC_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_ch      (cfg_ch),
      .cfg_duty    (cfg_duty),
      .period      (period),
      .prescale    (prescale),
      .center_mode (center_mode),
      .en_out      (en_out),
      .en_pwm      (en_pwm),
      .out         (out),
      .period_tick (period_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic write(input logic [3:0] ch, input logic [7:0] duty);
      cfg_we = 1'b1;
      cfg_ch = ch;
      cfg_duty = duty;
   endtask

   task automatic restart();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // first sample lands in the most significant bit of the n-bit window
   task automatic capture(input int n, input int ch, output logic [63:0] co, output logic [63:0] ct);
      co = '0;
      ct = '0;
      for (int i = 0; i < n; i++) begin
         step();
         co = {co[62:0], out[ch]};
         ct = {ct[62:0], period_tick};
      end
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_duty = '0;
      period = 8'd9; prescale = 8'd0; center_mode = 1'b0;
      en_out = '1; en_pwm = '1;
      @(negedge clk);
      // reset held three cycles
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst_out", 64'(out), 64'd0);
         check("rst_tick", 64'(period_tick), 64'd0);
      end
      rst = 1'b0;
      write(4'd0, 8'd5);
      capture(20, 0, o, t);
      check("t1_out", o, 64'(20'b01111100000111110000));
      check("t1_tick", t, 64'(20'b10000000001000000000));
      // prescaler 3, period 3
      prescale = 8'd3; period = 8'd3;
      restart();
      write(4'd0, 8'd2);
      capture(36, 0, o, t);
      check("t2_out", o, 64'(36'b0000_1111_1111_0000_0000_1111_1111_0000_0000));
      check("t2_tick", t, 64'(36'b0001_0000_0000_0000_0001_0000_0000_0000_0001));
      // centre-aligned, period 4
      prescale = 8'd0; period = 8'd4; center_mode = 1'b1;
      restart();
      write(4'd0, 8'd2);
      capture(17, 0, o, t);
      check("t3_out", o, 64'(17'b01100000111000001));
      check("t3_tick", t, 64'(17'b10000000100000001));
      // duty shadowing
      center_mode = 1'b0; period = 8'd9;
      restart();
      write(4'd0, 8'd2);
      capture(4, 0, o, t);
      check("t4_start", o, 64'(4'b0110));
      write(4'd0, 8'd7);
      capture(20, 0, o, t);
      check("t4_mid_write", o, 64'(20'b00000001111111000111));
      write(4'd0, 8'd2);
      capture(6, 0, o, t);
      check("t4_pending2", o, 64'(6'b111100));
      write(4'd0, 8'd7);
      capture(12, 0, o, t);
      check("t4_boundary_write", o, 64'(12'b011111110001));
      // extremes and enables
      period = 8'd0;
      restart();
      write(4'd0, 8'd0);   step();
      write(4'd1, 8'd255); step();
      write(4'd2, 8'd5);   step();
      write(4'd3, 8'd255); step();
      period = 8'd100; en_pwm[2] = 1'b0; en_out[3] = 1'b0;
      step();
      n0 = 0; n1 = 0; n2 = 0; n3 = 0;
      for (int i = 0; i < 210; i++) begin
         step();
         n0 += int'(out[0]); n1 += int'(out[1]); n2 += int'(out[2]); n3 += int'(out[3]);
      end
      check("t5_duty0", 64'(n0), 64'd0);
      check("t5_duty255", 64'(n1), 64'd210);
      check("t5_en_pwm_off", 64'(n2), 64'd210);
      check("t5_en_out_off", 64'(n3), 64'd0);
      en_out[1] = 1'b0;
      step();
      check("t5_en_out_live", 64'(out[1]), 64'd0);
      // channel 15 only, then mid-run reset
      en_out = '1; en_pwm = '1; period = 8'd0;
      restart();
      write(4'd15, 8'd5);
      step();
      period = 8'd9;
      o = '0; bad = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         o = {o[62:0], out[15]};
         if (out[14:0] != '0) bad++;
      end
      check("t6_ch15", o, 64'(20'b11111100000111110000));
      check("t6_others", 64'(bad), 64'd0);
      step();
      step();
      write(4'd15, 8'd8);
      step();
      check("t6_pre_rst", 64'(out[15]), 64'd1);
      rst = 1'b1;
      step();
      check("t6_rst_out", 64'(out), 64'd0);
      check("t6_rst_tick", 64'(period_tick), 64'd0);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         step();
         if (out != '0) bad++;
      end
      check("t6_after_rst", 64'(bad), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
